// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode values, field positions and encoder FSM states.
// Used by both the instruction encoder and the control-path decoder.
package isa_pkg;

    localparam logic [4:0] OP_RTYPE = 5'd0;
    localparam logic [4:0] OP_J     = 5'd1;
    localparam logic [4:0] OP_BNE   = 5'd2;
    localparam logic [4:0] OP_JAL   = 5'd3;
    localparam logic [4:0] OP_JR    = 5'd4;
    localparam logic [4:0] OP_ADDI  = 5'd5;
    localparam logic [4:0] OP_BLT   = 5'd6;
    localparam logic [4:0] OP_SW    = 5'd7;
    localparam logic [4:0] OP_LW    = 5'd8;
    localparam logic [4:0] OP_SETX  = 5'd21;
    localparam logic [4:0] OP_BEX   = 5'd22;
    localparam logic [4:0] OP_BEXEQ = 5'd31;

    // Least-significant bit of each field inside the 32-bit instruction word.
    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALU_LSB   = 2;
    localparam int IMM_W     = 17;
    localparam int TGT_W     = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields in, 32-bit ISA word plus a legal flag out.
module instr_pack
    import isa_pkg::*;
(
    input  logic [4:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       shamt,
    input  logic [4:0]       alu_op,
    input  logic [IMM_W-1:0] immediate,
    input  logic [TGT_W-1:0] target,
    output logic [31:0]      word,
    output logic             legal
);

    // Select the instruction format by opcode; unknown opcodes are flagged illegal.
    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        case (opcode)
            OP_RTYPE:                           word = {opcode, rd, rs, rt, shamt, alu_op, 2'b00};
            OP_BNE, OP_ADDI, OP_BLT, OP_SW, OP_LW: word = {opcode, rd, rs, immediate};
            OP_J, OP_JAL, OP_SETX, OP_BEX:      word = {opcode, target};
            OP_JR:                              word = {opcode, rd, 22'd0};
            OP_BEXEQ:                           word = {opcode, rd, target[21:0]};
            default:                            legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: packs field bundles and writes them to consecutive
// instruction-memory addresses through a one-deep registered output stage.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic             finish,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       shamt,
    input  logic [4:0]       alu_op,
    input  logic [IMM_W-1:0] immediate,
    input  logic [TGT_W-1:0] target,
    output logic             imem_we,
    output logic [AW-1:0]    imem_addr,
    output logic [31:0]      imem_data,
    input  logic             imem_ready,
    output logic [AW:0]      count,
    output logic             illegal,
    output logic             done
);

    localparam logic [AW:0] ADDR_MAX = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] SPAN     = (AW+1)'(DEPTH - 1);

    enc_state_e    state;
    logic [AW-1:0] next_addr;
    logic [AW-1:0] last_addr;
    logic          last_issued;
    logic [31:0]   word;
    logic          legal;
    logic [AW:0]   last_sum;
    logic [AW-1:0] last_addr_calc;
    logic          transfer;
    logic          issue_last;

    instr_pack u_pack (
        .opcode    (opcode),
        .rd        (rd),
        .rs        (rs),
        .rt        (rt),
        .shamt     (shamt),
        .alu_op    (alu_op),
        .immediate (immediate),
        .target    (target),
        .word      (word),
        .legal     (legal)
    );

    // Last legal address for a new run, capped at the top of the address space.
    always_comb begin
        last_sum       = {1'b0, start_addr} + SPAN;
        last_addr_calc = last_sum[AW-1:0];
        if (last_sum > ADDR_MAX) begin
            last_addr_calc = ADDR_MAX[AW-1:0];
        end else begin
            last_addr_calc = last_sum[AW-1:0];
        end
    end

    assign in_ready   = (state == ST_RUN) && !last_issued && (!imem_we || imem_ready);
    assign transfer   = in_valid && in_ready && !start;
    assign issue_last = transfer && legal && (next_addr == last_addr);

    // FSM, address/count counters and the output stage; start overrides everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            next_addr   <= '0;
            last_addr   <= '0;
            last_issued <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_data   <= 32'd0;
            count       <= '0;
            illegal     <= 1'b0;
            done        <= 1'b0;
        end else if (start) begin
            state       <= ST_RUN;
            next_addr   <= start_addr;
            last_addr   <= last_addr_calc;
            last_issued <= 1'b0;
            imem_we     <= 1'b0;
            count       <= '0;
            illegal     <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (imem_we && imem_ready) begin
                count   <= count + 1'b1;
                imem_we <= 1'b0;
            end
            if (transfer) begin
                if (legal) begin
                    imem_we   <= 1'b1;
                    imem_addr <= next_addr;
                    imem_data <= word;
                    if (next_addr == last_addr) begin
                        last_issued <= 1'b1;
                    end else begin
                        next_addr <= next_addr + 1'b1;
                    end
                end else begin
                    illegal <= 1'b1;
                end
            end
            case (state)
                ST_RUN: begin
                    if (finish || issue_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!imem_we) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table plus handshake/boundary sequences.
module tb_instr_encoder;

    logic        clock;
    logic        reset;
    logic        start;
    logic [11:0] start_addr;
    logic        finish;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode, rd, rs, rt, shamt, alu_op;
    logic [16:0] immediate;
    logic [26:0] target;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic [12:0] count;
    logic        illegal;
    logic        done;

    int errors = 0;
    int checks = 0;
    int wr_total = 0;
    logic [11:0] wr_log [0:255];

    typedef struct {
        logic [4:0]  op, rd, rs, rt, sh, alu;
        logic [16:0] imm;
        logic [26:0] tgt;
        logic [31:0] word;
        logic        legal;
    } vec_t;

    vec_t vecs [18];

    instr_encoder #(.AW(12), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
        .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .alu_op(alu_op),
        .immediate(immediate), .target(target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_ready(imem_ready), .count(count), .illegal(illegal), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Log every write the memory accepts.
    always @(negedge clock) begin
        if (!reset && imem_we && imem_ready) begin
            wr_log[wr_total[7:0]] <= imem_addr;
            wr_total <= wr_total + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [11:0] a);
        start = 1'b1;
        start_addr = a;
        tick();
        start = 1'b0;
    endtask

    task automatic set_bundle(input vec_t v);
        opcode = v.op; rd = v.rd; rs = v.rs; rt = v.rt; shamt = v.sh; alu_op = v.alu;
        immediate = v.imm; target = v.tgt;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && !done; i++) tick();
        check(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int base;
        vecs[0]  = '{5'd0,  5'd1,  5'd2,  5'd3,  5'd0,  5'd0,  17'h1ABCD, 27'h7FFFFFF, 32'h00443000, 1'b1};
        vecs[1]  = '{5'd5,  5'd5,  5'd6,  5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h0,       32'h294DFFFF, 1'b1};
        vecs[2]  = '{5'd0,  5'd4,  5'd4,  5'd0,  5'd3,  5'd4,  17'h0,     27'h0,       32'h01080190, 1'b1};
        vecs[3]  = '{5'd1,  5'd31, 5'd31, 5'd0,  5'd0,  5'd0,  17'h1FFFF, 27'd100,     32'h08000064, 1'b1};
        vecs[4]  = '{5'd31, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  17'h0,     27'd2,       32'hF8000002, 1'b1};
        vecs[5]  = '{5'd31, 5'd5,  5'd31, 5'd31, 5'd0,  5'd0,  17'h1FFFF, 27'h7FFFFFF, 32'hF97FFFFF, 1'b1};
        vecs[6]  = '{5'd4,  5'd7,  5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 27'h7FFFFFF, 32'h21C00000, 1'b1};
        vecs[7]  = '{5'd3,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  17'h0,     27'h5555555, 32'h1D555555, 1'b1};
        vecs[8]  = '{5'd21, 5'd9,  5'd9,  5'd0,  5'd0,  5'd0,  17'h0,     27'h0000123, 32'hA8000123, 1'b1};
        vecs[9]  = '{5'd22, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  17'h0,     27'h7FFFFFF, 32'hB7FFFFFF, 1'b1};
        vecs[10] = '{5'd7,  5'd1,  5'd2,  5'd31, 5'd0,  5'd0,  17'h4,     27'h7FFFFFF, 32'h38440004, 1'b1};
        vecs[11] = '{5'd8,  5'd31, 5'd0,  5'd0,  5'd0,  5'd0,  17'h10000, 27'h0,       32'h47C10000, 1'b1};
        vecs[12] = '{5'd2,  5'd3,  5'd4,  5'd0,  5'd0,  5'd0,  17'h2,     27'h0,       32'h10C80002, 1'b1};
        vecs[13] = '{5'd6,  5'd0,  5'd31, 5'd0,  5'd0,  5'd0,  17'h1,     27'h0,       32'h303E0001, 1'b1};
        vecs[14] = '{5'd0,  5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 17'h0,     27'h0,       32'h07FFFFFC, 1'b1};
        vecs[15] = '{5'd9,  5'd1,  5'd1,  5'd1,  5'd1,  5'd1,  17'h1,     27'h1,       32'h0,        1'b0};
        vecs[16] = '{5'd30, 5'd1,  5'd1,  5'd1,  5'd1,  5'd1,  17'h1,     27'h1,       32'h0,        1'b0};
        vecs[17] = '{5'd23, 5'd1,  5'd1,  5'd1,  5'd1,  5'd1,  17'h1,     27'h1,       32'h0,        1'b0};

        reset = 1'b1; start = 1'b0; start_addr = 12'h0; finish = 1'b0; in_valid = 1'b0;
        imem_ready = 1'b1;
        set_bundle(vecs[0]);
        tick(); tick();
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {20'd0, imem_addr}, 32'd0);
        check("rst_data", imem_data, 32'd0);
        check("rst_count", {19'd0, count}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // Encoding table: one bundle per fresh run at 0x010.
        for (int i = 0; i < 18; i++) begin
            do_start(12'h010);
            set_bundle(vecs[i]);
            in_valid = 1'b1;
            #1;
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d_we", i), {31'd0, imem_we}, {31'd0, vecs[i].legal});
            check($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, !vecs[i].legal});
            if (vecs[i].legal) begin
                check($sformatf("v%0d_addr", i), {20'd0, imem_addr}, 32'h010);
                check($sformatf("v%0d_data", i), imem_data, vecs[i].word);
            end
            tick();
            check($sformatf("v%0d_count", i), {19'd0, count}, {31'd0, vecs[i].legal});
        end

        // Back-to-back addi then sll.
        do_start(12'h010);
        set_bundle(vecs[1]); in_valid = 1'b1;
        tick();
        check("b2b_addr0", {20'd0, imem_addr}, 32'h010);
        check("b2b_data0", imem_data, 32'h294DFFFF);
        set_bundle(vecs[2]);
        tick();
        in_valid = 1'b0;
        check("b2b_we1", {31'd0, imem_we}, 32'd1);
        check("b2b_addr1", {20'd0, imem_addr}, 32'h011);
        check("b2b_data1", imem_data, 32'h01080190);
        tick();
        check("b2b_count", {19'd0, count}, 32'd2);

        // Backpressure: stage holds while imem_ready is low.
        do_start(12'h010);
        imem_ready = 1'b0;
        set_bundle(vecs[3]); in_valid = 1'b1;
        tick();
        set_bundle(vecs[4]);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            check("bp_we", {31'd0, imem_we}, 32'd1);
            check("bp_addr", {20'd0, imem_addr}, 32'h010);
            check("bp_data", imem_data, 32'h08000064);
        end
        imem_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_count1", {19'd0, count}, 32'd1);
        check("bp_addr1", {20'd0, imem_addr}, 32'h011);
        check("bp_data1", imem_data, 32'hF8000002);
        tick();
        check("bp_count2", {19'd0, count}, 32'd2);

        // Illegal bundle sandwiched between two legal ones.
        do_start(12'h040);
        base = wr_total;
        in_valid = 1'b1;
        set_bundle(vecs[0]); tick();
        set_bundle(vecs[15]); tick();
        set_bundle(vecs[3]); tick();
        in_valid = 1'b0;
        check("ill_flag", {31'd0, illegal}, 32'd1);
        check("ill_addr", {20'd0, imem_addr}, 32'h041);
        check("ill_data", imem_data, 32'h08000064);
        tick(); tick();
        check("ill_count", {19'd0, count}, 32'd2);
        check("ill_writes", wr_total - base, 32'd2);
        check("ill_wr0", {20'd0, wr_log[base]}, 32'h040);
        check("ill_wr1", {20'd0, wr_log[base+1]}, 32'h041);

        // Depth limit: six bundles offered, four written.
        do_start(12'h000);
        base = wr_total;
        set_bundle(vecs[0]); in_valid = 1'b1;
        wait_done("depth_done");
        in_valid = 1'b0;
        check("depth_writes", wr_total - base, 32'd4);
        for (int i = 0; i < 4; i++) check("depth_wr_addr", {20'd0, wr_log[base+i]}, i);
        check("depth_count", {19'd0, count}, 32'd4);
        check("depth_in_ready", {31'd0, in_ready}, 32'd0);

        // Address-space cap: start at 0xFFE only allows two writes.
        do_start(12'hFFE);
        check("cap_done_clear", {31'd0, done}, 32'd0);
        base = wr_total;
        in_valid = 1'b1;
        wait_done("cap_done");
        in_valid = 1'b0;
        check("cap_writes", wr_total - base, 32'd2);
        check("cap_wr1", {20'd0, wr_log[base+1]}, 32'hFFF);
        check("cap_count", {19'd0, count}, 32'd2);

        // finish with a pending write drains before DONE.
        do_start(12'h050);
        imem_ready = 1'b0;
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        finish = 1'b1; tick(); finish = 1'b0;
        tick(); tick();
        check("fin_pending_done", {31'd0, done}, 32'd0);
        check("fin_pending_we", {31'd0, imem_we}, 32'd1);
        imem_ready = 1'b1;
        wait_done("fin_done");
        check("fin_count", {19'd0, count}, 32'd1);

        // Restart mid-stream: start beats a simultaneous bundle and flushes the stage.
        do_start(12'h020);
        imem_ready = 1'b0;
        set_bundle(vecs[0]); in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick();
        start = 1'b1; start_addr = 12'h030; set_bundle(vecs[3]); in_valid = 1'b1; imem_ready = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("rs_we", {31'd0, imem_we}, 32'd0);
        check("rs_count", {19'd0, count}, 32'd0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        check("rs_addr", {20'd0, imem_addr}, 32'h030);
        check("rs_data", imem_data, 32'h08000064);

        // Asynchronous reset mid-stream.
        do_start(12'h060);
        in_valid = 1'b1; tick();
        #2 reset = 1'b1;
        #1;
        check("ar_we", {31'd0, imem_we}, 32'd0);
        check("ar_count", {19'd0, count}, 32'd0);
        check("ar_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential instruction encoder and loader: the inverse of the control-path instruction decoder. It accepts decoded fields (opcode, rd, rs, rt, shamt, ALU op, immediate, target) over a valid/ready handshake, packs them into the 32-bit ISA word, and writes the words into consecutive instruction-memory addresses. It sits between the boot/test loader (or a self-test sequencer) and the instruction-memory write port.

Parameters:
AW, 12, instruction-memory address width
DEPTH, 4096, number of writable words; last legal address is start_addr + DEPTH - 1, capped at 2^AW - 1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; loads start_addr, clears count and illegal, enters RUN
start_addr  in  AW  first write address
finish  in  1  one-cycle pulse; drains the output stage, then enters DONE
in_valid  in  1  field bundle valid
in_ready  out  1  encoder accepts the bundle this cycle
opcode  in  5  instruction[31:27]
rd  in  5  destination / read-rd register
rs  in  5  source register
rt  in  5  R-type second source
shamt  in  5  R-type shift amount
alu_op  in  5  R-type ALU op
immediate  in  17  I-type immediate
target  in  27  J-type target
imem_we  out  1  write strobe (output stage valid)
imem_addr  out  AW  write address
imem_data  out  32  encoded word
imem_ready  in  1  memory accepts the write this cycle
count  out  AW+1  words written since start
illegal  out  1  sticky: an unsupported opcode was dropped
done  out  1  high in DONE state

Behaviour:
- Reset (async): state IDLE; imem_we=0, imem_addr=0, imem_data=0, count=0, illegal=0, done=0, in_ready=0.
- States:
  - IDLE: start moves to RUN.
  - RUN: finish, or an accepted write to the last legal address, moves to DRAIN.
  - DRAIN: when the output stage is empty, moves to DONE.
  - DONE: start moves to RUN.
  - start in RUN, DRAIN or DONE restarts: the output stage is flushed (imem_we=0 next cycle), the pending word is discarded, and the address is reloaded.
- in_ready = (state==RUN) && !last_issued && (!imem_we || imem_ready).
- An input transfer occurs when in_valid && in_ready.
- Encoding (combinational from the inputs, registered on transfer; latency is 1 cycle from transfer to imem_we):
  - opcode 0 (R-type): {opcode, rd, rs, rt, shamt, alu_op, 2'b00}
  - opcode 2, 5, 6, 7, 8 (bne, addi, blt, sw, lw; I-type): {opcode, rd, rs, immediate}
  - opcode 1, 3, 21, 22 (j, jal, setx, bex; J-type): {opcode, target}
  - opcode 4 (jr): {opcode, rd, 22'b0}
  - opcode 31 (bexeq): {opcode, rd, target[21:0]}; target[26:22] is ignored.
  - Any other opcode: the bundle is consumed (handshake completes), no write is issued, illegal is set to 1 and stays set until start.
- Output stage: imem_we/imem_addr/imem_data hold stable while imem_we && !imem_ready.
  - On imem_ready, count increments.
  - If a new transfer occurs in the same cycle, the stage reloads with the next word at address + 1 (back-to-back, one word per cycle).
- Address counter: increments per issued write. It never wraps. After the last legal address is issued, last_issued=1 and in_ready stays 0.
- Simultaneous start and in_valid: start wins and no transfer occurs that cycle.
- finish with a pending write: that write completes before DONE.

Decomposition:
- Shared package isa_pkg: opcode constants (OP_RTYPE=0, OP_J=1, OP_BNE=2, OP_JAL=3, OP_JR=4, OP_ADDI=5, OP_BLT=6, OP_SW=7, OP_LW=8, OP_SETX=21, OP_BEX=22, OP_BEXEQ=31) and the field bit positions. The control decoder uses the same package.
- One sub-module, instr_pack: purely combinational. Takes the fields and outputs word[31:0] and legal. The top holds the FSM, the address/count counters and the output register.

Test Plan:
- start(start_addr=0x010); add r1,r2,r3 (op0, rd1, rs2, rt3, shamt0, alu0), imem_ready=1 -> next cycle imem_we=1, imem_addr=0x010, imem_data=0x00443000, then count=1.
- addi r5,r6,imm=0x1FFFF, then sll r4,r4,3 (alu_op 4), back-to-back -> 0x294DFFFF at 0x010 and 0x01080190 at 0x011 on consecutive cycles.
- j target=100, then bexeq target=2 -> 0x08000064 and 0xF8000002.
- Hold imem_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and imem_addr/imem_data stable throughout. Release -> one write, then the next word is accepted.
- Opcode 9 bundle between two legal bundles -> illegal=1, only 2 writes at consecutive addresses, count=2.
- DEPTH=4, start_addr=0 with 6 bundles -> writes to addresses 0..3 only, in_ready=0 afterwards, done=1. A start mid-stream (or a reset mid-stream) -> imem_we drops, and state and count return to their start/reset values.
